bus_arb4_32: RTL
================

# bus_arb4_32

Round-robin arbiter and sequencer that shares one 32-bit 4:1 select path between four requesters and a single downstream consumer. It picks an owner, drives the 2-bit select and one-hot grant, and gates a valid/ready handshake for each 32-bit beat. It releases ownership on the owner's last beat, when the owner withdraws its request, or when the owner reaches the MAX_BEATS burst cap. It sits in the datapath wherever a 4:1 word mux has more than one active source per cycle.

## Interface
- MAX_BEATS, 8: burst cap in beats per grant, 1..256.
- BW, 8: beat counter width; must satisfy 2^BW ≥ MAX_BEATS.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- req  in  4  req[i] high while requester i wants the bus.
- last  in  4  last[i] marks requester i's current beat as its final beat.
- I0..I3  in  32 each  requester data words.
- o_ready  in  1  downstream accepts the beat this cycle.
- o  out  32  selected word, I[sel] when o_valid, else 32'h0.
- o_valid  out  1  beat offered downstream.
- sel  out  2  registered owner index.
- gnt  out  4  one-hot registered grant, 0 when idle.
- beat_cnt  out  BW  beats transferred in the current grant.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: owner = sel.
- IDLE with req≠0:
  - Pick the first requester with req high, scanning rr_ptr+1, rr_ptr+2, … (mod 4).
  - Next cycle: state=BUSY, sel=pick, gnt=1<<pick, beat_cnt=0.
- IDLE with req=0: stay in IDLE; all outputs hold their idle values.
- BUSY outputs:
  - o_valid = req[sel].
  - o = I[sel] when o_valid, else 0.
- Transfer: o_valid && o_ready. Each transfer increments beat_cnt.
- Release, evaluated in BUSY each cycle, in priority order:
  - transfer && last[sel]
  - transfer && beat_cnt==MAX_BEATS-1
  - !req[sel], i.e. the requester withdrew with no transfer
- On release:
  - Next cycle: state=IDLE, gnt=0, beat_cnt=0.
  - rr_ptr=sel, so the released owner gets lowest priority next.
  - sel holds its value while IDLE.
- rr_ptr changes only on release.
- The req/last of non-owners are ignored while BUSY.
- No preemption: a higher-index or new request never interrupts the owner.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=3 (requester 0 wins first), sel=0, gnt=0, o_valid=0, o=0, beat_cnt=0.
- Reset mid-burst: the next cycle is IDLE with all reset values. A beat offered in the reset cycle is not counted.
- Arbitration latency: req rising in IDLE at cycle N gives gnt at N+1 and the earliest transfer at N+1.
- Turnaround: release at cycle N gives IDLE at N+1 and the next grant at N+2. One dead cycle is required between grants.
- Combinational paths: o_valid and o depend combinationally on req[sel] and I[sel]; there is no combinational path from o_ready to o_valid.
- Burst length:
  - A burst of k beats with o_ready held high occupies k cycles in BUSY.
  - With MAX_BEATS=1, every grant is one beat.
- Simultaneous last and cap on the same transfer: a single release.
- Owner drops req in the same cycle o_ready rises: no transfer, release.

## Structure
- Shared datapath package holds:
  - state encoding (IDLE=1'b0, BUSY=1'b1)
  - requester count constant (4)
- Natural sub-module: rr_pick4, purely combinational. Inputs are req[3:0] and ptr[1:0]; outputs are idx[1:0] and any.
- The data select inside the block is an ordinary 4:1 word mux on sel, with the output gated by o_valid.

## Test plan
- Reset then single requester:
  - Stimulus: assert rst 2 cycles, release; req=4'b0100, I2=32'hDEADBEEF, last[2]=1, o_ready=1.
  - Required: gnt=4'b0100 and sel=2 one cycle after req; o=32'hDEADBEEF with o_valid=1 for exactly one cycle; then gnt=0.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held, last=4'b1111, o_ready=1.
  - Required: grant order 0,1,2,3,0, with one IDLE cycle between each.
- Burst cap:
  - Stimulus: MAX_BEATS=4; req[1] held, last=0, o_ready=1.
  - Required: exactly 4 transfers, beat_cnt 0→3, then IDLE.
  - Then, with req[0] also high: requester 0 wins the next grant.
- Backpressure:
  - Stimulus: owner 3 with last[3]=1 on the first beat; o_ready low for 5 cycles, then high.
  - Required: o_valid=1 and o stable for 6 cycles; beat_cnt=0 until the transfer; release after it.
- Withdraw and mid-burst reset:
  - Stimulus: owner 0 drops req after 2 of 5 beats.
  - Required: IDLE next cycle, rr_ptr=0.
  - Stimulus: rst pulsed mid-burst.
  - Required: all outputs at reset values the next cycle, and requester 0 wins the next arbitration.

Source files
------------

// File: rtl/bus_arb4_32_pkg.sv
// bus_arb4_32_pkg: shared state encoding and requester count for the 4-way bus arbiter.
package bus_arb4_32_pkg;
  localparam int NREQ = 4;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
endpackage

// File: rtl/bus_arb4_32_rr_pick4.sv
// rr_pick4: combinational round-robin pick, scanning ptr+1, ptr+2, ... (mod 4).
module rr_pick4
  import bus_arb4_32_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      ptr_i,
  output logic [1:0]      idx_o,
  output logic            any_o
);
  // Scan from farthest to nearest so the nearest requester after ptr overwrites last.
  always_comb begin
    idx_o = 2'd0;
    for (int k = NREQ; k >= 1; k--)
      if (req_i[ptr_i + 2'(k)]) idx_o = ptr_i + 2'(k);
  end
  assign any_o = |req_i;
endmodule

// File: rtl/bus_arb4_32.sv
// bus_arb4_32: round-robin arbiter sharing one 32-bit 4:1 select path,
// with per-beat valid/ready gating and release on last, cap or withdraw.
module bus_arb4_32
  import bus_arb4_32_pkg::*;
#(
  parameter int MAX_BEATS = 8,
  parameter int BW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [3:0]    last,
  input  logic [31:0]   I0,
  input  logic [31:0]   I1,
  input  logic [31:0]   I2,
  input  logic [31:0]   I3,
  input  logic          o_ready,
  output logic [31:0]   o,
  output logic          o_valid,
  output logic [1:0]    sel,
  output logic [3:0]    gnt,
  output logic [BW-1:0] beat_cnt
);
  state_e        state_q, state_d;
  logic [1:0]    rr_q, rr_d, sel_q, sel_d, pick;
  logic [3:0]    gnt_q, gnt_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          any, busy, xfer, rel;
  logic [31:0]   word;
  rr_pick4 u_pick (
    .req_i (req),
    .ptr_i (rr_q),
    .idx_o (pick),
    .any_o (any)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 2'd3;
      sel_q   <= 2'd0;
      gnt_q   <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy = state_q == BUSY;
  assign xfer = o_valid && o_ready;
  // Withdraw only matters when no transfer happened, which !req[sel] already implies.
  assign rel  = busy && ((xfer && (last[sel_q] || cnt_q == BW'(MAX_BEATS - 1))) || !req[sel_q]);
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    if (!busy && any) begin
      state_d = BUSY;
      sel_d   = pick;
      gnt_d   = 4'b1 << pick;
      cnt_d   = '0;
    end else if (rel) begin
      state_d = IDLE;
      rr_d    = sel_q;
      gnt_d   = 4'd0;
      cnt_d   = '0;
    end else if (xfer) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_comb begin
    word    = sel_q[1] ? (sel_q[0] ? I3 : I2) : (sel_q[0] ? I1 : I0);
    o_valid = busy && req[sel_q];
    o       = o_valid ? word : 32'h0;
  end
  assign sel      = sel_q;
  assign gnt      = gnt_q;
  assign beat_cnt = cnt_q;
endmodule
